// File: rtl/rf_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rf_channel_ctrl
// Description : Weaver SSB RF channel sequencer. Mutes the output gain, retunes
//               the RF NCO, resyncs the accumulators and ramps the gain back up.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_channel_ctrl #(
    parameter int RF_INC_BASE = 25521,
    parameter int RF_INC_STEP = 462,
    parameter int MAX_CH      = 15,
    parameter int DEF_CH      = 3,
    parameter int GAIN_MAX    = 32,
    parameter int RAMP_DIV    = 4,
    parameter int SETTLE_CYC  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_ch,
    output logic        req_ready,
    output logic [16:0] inc_rf,
    output logic        nco_sync,
    output logic [5:0]  gain,
    output logic        busy,
    output logic        err
);

    localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [DW-1:0] DIV_LAST    = DW'(RAMP_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [5:0]    GAIN_FULL   = 6'(GAIN_MAX);
    localparam logic [4:0]    MAX_CH_V    = 5'(MAX_CH);
    localparam logic [16:0]   INC_BASE    = 17'(RF_INC_BASE);
    localparam logic [16:0]   INC_STEP    = 17'(RF_INC_STEP);
    localparam logic [16:0]   DEF_INC     = 17'(RF_INC_BASE + DEF_CH * RF_INC_STEP);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP_DN = 3'd1,
        LOAD    = 3'd2,
        SETTLE  = 3'd3,
        RAMP_UP = 3'd4
    } state_t;

    state_t          state;
    logic [3:0]      ch;
    logic [DW-1:0]   div_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [16:0]     next_inc;

    assign next_inc  = INC_BASE + ({13'd0, ch} * INC_STEP);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    // The increment is updated on entry to LOAD so it is already valid while
    // the sync pulse tells the modulator to reload its accumulators.
    assign nco_sync  = (state == LOAD) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            ch         <= 4'(DEF_CH);
            gain       <= 6'd0;
            err        <= 1'b0;
            inc_rf     <= DEF_INC;
            div_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    gain <= GAIN_FULL;
                    if (req_valid) begin
                        if ({1'b0, req_ch} > MAX_CH_V) begin
                            err <= 1'b1;
                        end else begin
                            ch      <= req_ch;
                            div_cnt <= '0;
                            state   <= RAMP_DN;
                        end
                    end
                end
                RAMP_DN: begin
                    if (gain == 6'd0) begin
                        inc_rf <= next_inc;
                        state  <= LOAD;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        gain    <= gain - 6'd1;
                        if (gain == 6'd1) begin
                            inc_rf <= next_inc;
                            state  <= LOAD;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    gain       <= 6'd0;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        div_cnt <= '0;
                        state   <= RAMP_UP;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        gain    <= gain + 6'd1;
                        if (gain == GAIN_FULL - 6'd1) begin
                            state <= IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_channel_ctrl
// Description : Directed self-checking bench for rf_channel_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_channel_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid7;
    logic [3:0]  req_ch, req_ch7;
    logic        req_ready, req_ready7;
    logic [16:0] inc_rf, inc_rf7;
    logic        nco_sync, nco_sync7;
    logic [5:0]  gain, gain7;
    logic        busy, busy7;
    logic        err, err7;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_channel_ctrl u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ch(req_ch),
        .req_ready(req_ready), .inc_rf(inc_rf), .nco_sync(nco_sync),
        .gain(gain), .busy(busy), .err(err)
    );

    rf_channel_ctrl #(.MAX_CH(7)) u_dut7 (
        .clk(clk), .reset(reset), .req_valid(req_valid7), .req_ch(req_ch7),
        .req_ready(req_ready7), .inc_rf(inc_rf7), .nco_sync(nco_sync7),
        .gain(gain7), .busy(busy7), .err(err7)
    );

    typedef struct {
        int t;
        int exp_gain;
        int exp_sync;
        int exp_ready;
        int exp_busy;
        int exp_inc;
    } vec_t;

    vec_t pu_tab[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected gain t cycles after entering LOAD.
    function automatic int pu_gain(input int t);
        int g;
        if (t < 65) return 0;
        g = (t - 65) / 4;
        return (g > 32) ? 32 : g;
    endfunction

    // Release reset just after a rising edge so the first sampled cycle is LOAD.
    task automatic run_powerup();
        int k;
        @(posedge clk);
        #1 reset = 1'b0;
        k = 0;
        for (int t = 0; t <= 193; t++) begin
            @(negedge clk);
            if (t != 0 && t != 193) chk("pu_gain_model", int'(gain), pu_gain(t));
            if (k < 12 && pu_tab[k].t == t) begin
                chk($sformatf("pu_gain_t%0d", t),  int'(gain),      pu_tab[k].exp_gain);
                chk($sformatf("pu_sync_t%0d", t),  int'(nco_sync),  pu_tab[k].exp_sync);
                chk($sformatf("pu_ready_t%0d", t), int'(req_ready), pu_tab[k].exp_ready);
                chk($sformatf("pu_busy_t%0d", t),  int'(busy),      pu_tab[k].exp_busy);
                chk($sformatf("pu_inc_t%0d", t),   int'(inc_rf),    pu_tab[k].exp_inc);
                k++;
            end
        end
    endtask

    // Called at a negedge of an IDLE cycle (or with the request already held).
    task automatic do_change(input logic [3:0] ch, input int old_inc, input int new_inc,
                             input logic nxt_valid, input logic [3:0] nxt_ch);
        int syncs;
        int eg;
        syncs = 0;
        req_valid = 1'b1;
        req_ch    = ch;
        for (int o = 1; o <= 322; o++) begin
            @(negedge clk);
            if (o == 1) begin
                req_valid = nxt_valid;
                req_ch    = nxt_ch;
                chk("chg_err_low", int'(err), 0);
            end
            eg = (o <= 129) ? 32 - (o - 1) / 4 : pu_gain(o - 129);
            if (eg < 0) eg = 0;
            chk($sformatf("chg%0d_gain_o%0d", ch, o), int'(gain), eg);
            chk($sformatf("chg%0d_ready_o%0d", ch, o), int'(req_ready), (o == 322) ? 1 : 0);
            chk($sformatf("chg%0d_inc_o%0d", ch, o), int'(inc_rf), (o >= 129) ? new_inc : old_inc);
            if (nco_sync) begin
                syncs++;
                chk($sformatf("chg%0d_sync_pos", ch), o, 129);
            end
        end
        chk($sformatf("chg%0d_sync_count", ch), syncs, 1);
    endtask

    initial begin
        pu_tab[0]  = '{0,   0,  1, 0, 1, 26907};
        pu_tab[1]  = '{1,   0,  0, 0, 1, 26907};
        pu_tab[2]  = '{64,  0,  0, 0, 1, 26907};
        pu_tab[3]  = '{68,  0,  0, 0, 1, 26907};
        pu_tab[4]  = '{69,  1,  0, 0, 1, 26907};
        pu_tab[5]  = '{72,  1,  0, 0, 1, 26907};
        pu_tab[6]  = '{73,  2,  0, 0, 1, 26907};
        pu_tab[7]  = '{100, 8,  0, 0, 1, 26907};
        pu_tab[8]  = '{189, 31, 0, 0, 1, 26907};
        pu_tab[9]  = '{192, 31, 0, 0, 1, 26907};
        pu_tab[10] = '{193, 32, 0, 1, 0, 26907};
        pu_tab[11] = '{9999, 0, 0, 0, 0, 0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_ch     = 4'd0;
        req_valid7 = 1'b0;
        req_ch7    = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_gain",  int'(gain),      0);
        chk("rst_sync",  int'(nco_sync),  0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_busy",  int'(busy),      1);
        chk("rst_err",   int'(err),       0);
        chk("rst_inc",   int'(inc_rf),    26907);

        run_powerup();

        // Channel 0, then 15 with a held request for 9, then 9, then 9 again.
        do_change(4'd0,  26907, 25521, 1'b0, 4'd0);
        do_change(4'd15, 25521, 32451, 1'b1, 4'd9);
        do_change(4'd9,  32451, 29679, 1'b0, 4'd0);
        do_change(4'd9,  29679, 29679, 1'b0, 4'd0);

        // Out-of-range request on the MAX_CH=7 instance.
        chk("m7_idle", int'(req_ready7), 1);
        req_valid7 = 1'b1;
        req_ch7    = 4'd15;
        @(negedge clk);
        req_valid7 = 1'b0;
        chk("m7_err_pulse", int'(err7),  1);
        chk("m7_busy",      int'(busy7), 0);
        chk("m7_gain",      int'(gain7), 32);
        chk("m7_inc",       int'(inc_rf7), 26907);
        @(negedge clk);
        chk("m7_err_clear", int'(err7),  0);
        chk("m7_ready",     int'(req_ready7), 1);

        // Reset in the middle of a ramp-down at gain 17.
        req_valid = 1'b1;
        req_ch    = 4'd0;
        for (int o = 1; o <= 61; o++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        chk("mid_gain17", int'(gain), 17);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_gain",  int'(gain),      0);
        chk("mid_rst_busy",  int'(busy),      1);
        chk("mid_rst_ready", int'(req_ready), 0);
        chk("mid_rst_inc",   int'(inc_rf),    26907);
        chk("mid_rst_sync",  int'(nco_sync),  0);
        run_powerup();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
